// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions and width defaults
// for the R/I/J CPU pipeline.
package cpu_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int LINK_DEF = 31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_LO = 26;
    localparam int RS_LO = 21;
    localparam int RT_LO = 16;
    localparam int RD_LO = 11;
    localparam int SH_LO = 6;
    localparam int FN_LO = 0;
    localparam int IM_LO = 0;
    localparam int JT_LO = 0;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Instruction-in and operand-bundle-out handshakes of the
// operand fetch stage; slave is the stage, master the neighbours.
interface operand_fetch_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rs;
    logic [DW-1:0] out_rt;
    logic [DW-1:0] out_imm;
    logic [AW-1:0] out_dst;
    logic [5:0]    out_op;
    logic [5:0]    out_funct;
    logic [4:0]    out_shamt;
    logic [25:0]   out_jtarg;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_rs, out_rt, out_imm,
        output out_dst, out_op, out_funct, out_shamt, out_jtarg
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_rs, out_rt, out_imm,
        input  out_dst, out_op, out_funct, out_shamt, out_jtarg
    );
endinterface

// File: rtl/operand_fetch_stage_imm_extend.sv
// Immediate extension: zero for logical ops, upper-half for LUI,
// sign extension for everything else.
module imm_extend
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [15:0]   imm16,
    input  logic [5:0]    op,
    output logic [DW-1:0] imm
);
    always_comb begin
        imm = {{(DW-16){imm16[15]}}, imm16};
        unique case (1'b1)
            (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI):
                imm = {{(DW-16){1'b0}}, imm16};
            (op == OP_LUI): begin
                imm = '0;
                imm[31:16] = imm16;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage with writeback snooping.
// Define OF_WB_BYPASS_EN to bypass writeback on capture instead of stalling.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int LINK = LINK_DEF
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    operand_fetch_stage_if.slave bus,
    output logic [AW-1:0]        raddra,
    output logic [AW-1:0]        raddrb,
    input  logic [DW-1:0]        douta,
    input  logic [DW-1:0]        doutb,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [DW-1:0]        wb_data,
    output logic [15:0]          stall_cnt
);
    logic [5:0]    op;
    logic [AW-1:0] dst;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs_cap;
    logic [DW-1:0] rt_cap;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rt_q;
    logic          wb_hit;
    logic          hit_a;
    logic          hit_b;
    logic          hazard;
    logic          in_fire;
    logic          hold;

    assign op     = bus.in_instr[OP_LO +: 6];
    assign raddra = bus.in_instr[RS_LO +: AW];
    assign raddrb = bus.in_instr[RT_LO +: AW];

    assign wb_hit = wb_we && (wb_addr != '0);
    assign hit_a  = wb_hit && (wb_addr == raddra);
    assign hit_b  = wb_hit && (wb_addr == raddrb);

`ifdef OF_WB_BYPASS_EN
    assign hazard = 1'b0;
    assign rs_cap = hit_a ? wb_data : douta;
    assign rt_cap = hit_b ? wb_data : doutb;
`else
    // Hold the instruction back until the colliding write lands.
    assign hazard = hit_a || hit_b;
    assign rs_cap = douta;
    assign rt_cap = doutb;
`endif

    assign rs_val = (raddra == '0) ? '0 : rs_cap;
    assign rt_val = (raddrb == '0) ? '0 : rt_cap;

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign hold         = bus.out_valid && !bus.out_ready;

    always_comb begin
        dst = bus.in_instr[RT_LO +: AW];
        unique case (1'b1)
            (op == OP_RTYPE): dst = bus.in_instr[RD_LO +: AW];
            (op == OP_JAL):   dst = AW'(LINK);
            (op == OP_J) || (op == OP_BEQ) ||
            (op == OP_BNE) || (op == OP_SW):
                dst = '0;
            default: ;
        endcase
    end

    imm_extend #(.DW(DW)) u_imm (
        .imm16 (bus.in_instr[IM_LO +: 16]),
        .op    (op),
        .imm   (imm)
    );

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            bus.out_valid <= 1'b0;
            bus.out_rs    <= '0;
            bus.out_rt    <= '0;
            bus.out_imm   <= '0;
            bus.out_dst   <= '0;
            bus.out_op    <= '0;
            bus.out_funct <= '0;
            bus.out_shamt <= '0;
            bus.out_jtarg <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            stall_cnt     <= '0;
        end else begin
            if (in_fire) begin
                bus.out_valid <= 1'b1;
                bus.out_rs    <= rs_val;
                bus.out_rt    <= rt_val;
                bus.out_imm   <= imm;
                bus.out_dst   <= dst;
                bus.out_op    <= op;
                bus.out_funct <= bus.in_instr[FN_LO +: 6];
                bus.out_shamt <= bus.in_instr[SH_LO +: 5];
                bus.out_jtarg <= bus.in_instr[JT_LO +: 26];
                rs_q          <= raddra;
                rt_q          <= raddrb;
            end else begin
                if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end
                // Keep a waiting bundle coherent with later writebacks.
                if (hold && wb_hit && (wb_addr == rs_q)) begin
                    bus.out_rs <= wb_data;
                end
                if (hold && wb_hit && (wb_addr == rt_q)) begin
                    bus.out_rt <= wb_data;
                end
            end
            if (bus.in_valid && !bus.in_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: fired instructions are queued,
// a monitor pops and checks each consumed bundle against architectural state.
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic        clka = 1'b0;
    logic        rsta_n = 1'b0;
    logic [4:0]  raddra, raddrb;
    logic [31:0] douta, doutb;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [15:0] stall_cnt;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
    } exp_t;
    exp_t q[$];

    logic [5:0] ops [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    always #5 clka = ~clka;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .bus       (bus),
        .raddra    (raddra),
        .raddrb    (raddrb),
        .douta     (douta),
        .doutb     (doutb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall_cnt (stall_cnt)
    );

    // Register file; r0 reads return garbage so the stage must force zero.
    assign douta = (raddra == 0) ? 32'hDEADBEEF : regs[raddra];
    assign doutb = (raddrb == 0) ? 32'hBADC0FFE : regs[raddrb];

    always @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != 0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [4:0] m_dst(input logic [31:0] i);
        logic [5:0] o;
        o = i[31:26];
        if (o == 6'h00) return i[15:11];
        if (o == 6'h03) return 5'd31;
        if (o == 6'h02 || o == 6'h04 || o == 6'h05 || o == 6'h2B) return 5'd0;
        return i[20:16];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [5:0] o;
        o = i[31:26];
        if (o == 6'h0C || o == 6'h0D || o == 6'h0E) return {16'h0, i[15:0]};
        if (o == 6'h0F) return {i[15:0], 16'h0};
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        return (a == 0) ? 32'h0 : regs[a];
    endfunction

    function automatic logic m_stall();
`ifdef OF_WB_BYPASS_EN
        return 1'b0;
`else
        return wb_we && wb_addr != 0 &&
               (wb_addr == bus.in_instr[25:21] || wb_addr == bus.in_instr[20:16]);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic er;
        forever begin
            @(negedge clka);
            if (rsta_n) begin
                er = (!bus.out_valid || bus.out_ready) && !m_stall();
                chk("in_ready", {31'b0, bus.in_ready}, {31'b0, er});
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_bundle actual=valid required=none");
                    end else begin
                        e = q.pop_front();
                        chk("sb_rs", bus.out_rs, m_reg(e.ins[25:21]));
                        chk("sb_rt", bus.out_rt, m_reg(e.ins[20:16]));
                        chk("sb_imm", bus.out_imm, m_imm(e.ins));
                        chk("sb_dst", 32'(bus.out_dst), 32'(m_dst(e.ins)));
                        chk("sb_op", 32'(bus.out_op), 32'(e.ins[31:26]));
                        chk("sb_funct", 32'(bus.out_funct), 32'(e.ins[5:0]));
                        chk("sb_shamt", 32'(bus.out_shamt), 32'(e.ins[10:6]));
                        chk("sb_jtarg", 32'(bus.out_jtarg), 32'(e.ins[25:0]));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.ins = bus.in_instr;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        @(negedge clka);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clka);
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        wb_we = 1'b0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        logic [31:0] ins;
        logic [15:0] s0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        chk("reset_rs", bus.out_rs, 32'd0);
        step();
        rsta_n = 1'b1;
        fork
            monitor();
        join_none
        step();

        wr(5'd1, 32'd5);
        wr(5'd2, 32'd7);

        send(32'h00221820);
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_rs", bus.out_rs, 32'd5);
        chk("add_rt", bus.out_rt, 32'd7);
        chk("add_dst", 32'(bus.out_dst), 32'd3);
        chk("add_funct", 32'(bus.out_funct), 32'h20);

        t0 = int'($time);
        for (int i = 0; i < 4; i++) send(32'h00221820 + 32'(i << 11));
        chk("b2b_cycles", 32'((int'($time) - t0) / 10), 32'd4);

        send(32'h34048001);
        chk("ori_imm", bus.out_imm, 32'h00008001);
        chk("ori_rs", bus.out_rs, 32'd0);
        chk("ori_dst", 32'(bus.out_dst), 32'd4);
        send(32'h20048001);
        chk("addi_imm", bus.out_imm, 32'hFFFF8001);
        send(32'h3C048001);
        chk("lui_imm", bus.out_imm, 32'h80010000);
        send(32'h0C000123);
        chk("jal_dst", 32'(bus.out_dst), 32'd31);
        chk("jal_jtarg", 32'(bus.out_jtarg), 32'h123);
        drain();

        s0 = stall_cnt;
        wb_we = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'hAA;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221820;
        @(negedge clka);
`ifdef OF_WB_BYPASS_EN
        chk("coll_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        wb_we = 1'b0;
        bus.in_valid = 1'b0;
        chk("coll_rs", bus.out_rs, 32'hAA);
        chk("coll_stall", 32'(stall_cnt), 32'(s0));
`else
        chk("coll_ready", {31'b0, bus.in_ready}, 32'd0);
        step();
        wb_we = 1'b0;
        @(negedge clka);
        chk("coll_ready2", {31'b0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("coll_rs", bus.out_rs, 32'hAA);
        chk("coll_stall", 32'(stall_cnt), 32'(s0 + 16'd1));
`endif
        drain();

        bus.out_ready = 1'b0;
        send(32'h00401820);
        wr(5'd2, 32'h55);
        chk("hold_rs", bus.out_rs, 32'h55);
        chk("hold_rt", bus.out_rt, 32'd0);
        chk("hold_dst", 32'(bus.out_dst), 32'd3);
        wr(5'd0, 32'h99);
        chk("hold_r0_rt", bus.out_rt, 32'd0);
        chk("hold_r0_rs", bus.out_rs, 32'h55);
        chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        drain();

        for (int c = 0; c < 400; c++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 11)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            bus.in_instr = ins;
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            wb_we = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end
        drain();

        bus.out_ready = 1'b0;
        send(32'h00221820);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00622020;
        repeat (70000) @(posedge clka);
        #1;
        chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
        chk("sat_valid", {31'b0, bus.out_valid}, 32'd1);

        #2;
        rsta_n = 1'b0;
        #1;
        q.delete();
        chk("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
        chk("rst_mid_rs", bus.out_rs, 32'd0);
        bus.in_valid = 1'b0;
        step();
        rsta_n = 1'b1;
        step();
        chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        send(32'h34048001);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
